cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of functional-unit result sources (2..8).
REQ-002 Parameter DATA_W, default 32, result data width.
REQ-003 Parameter LABEL_W, default 5, reservation-station label width; label 0 means "no producer".
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 nRST  input  1  reset, asynchronous and active-low.
REQ-006 flush  input  1  synchronous clear of all pending results.
REQ-007 src_valid  input  NUM_SRC  per-source result-valid.
REQ-008 src_label  input  NUM_SRC*LABEL_W  per-source label; source i occupies bits [i*LABEL_W +: LABEL_W].
REQ-009 src_data  input  NUM_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
REQ-010 src_ready  output  NUM_SRC  per-source accept.
REQ-011 BCEN  output  1  common-data-bus broadcast enable, registered.
REQ-012 BClabel  output  LABEL_W  broadcast label, registered.
REQ-013 BCdata  output  DATA_W  broadcast data, registered.
REQ-014 proto_err  output  1  sticky protocol-error flag.
REQ-015 bc_count  output  16  saturating count of broadcasts issued.

Function
REQ-016 Each source SHALL own a one-entry holding buffer: full bit, label, data.
REQ-017 Transfer SHALL occur on a rising edge when src_valid[i] and src_ready[i] are both high.
REQ-018 src_ready[i] SHALL be high when buffer i is empty or is granted this cycle, and low whenever flush is high.
REQ-019 Each cycle, the arbiter SHALL grant exactly one full buffer, if any, by round-robin starting at rr_ptr.
REQ-020 Granted contents SHALL be registered into BCEN=1/BClabel/BCdata at that edge, and the buffer freed; BCEN SHALL be 0 for any cycle with no grant.
REQ-021 rr_ptr SHALL become (grant+1) mod NUM_SRC after a grant and hold otherwise.
REQ-022 Latency: a result accepted at edge k SHALL appear on BCEN no earlier than after edge k+1, with at most NUM_SRC-1 further cycles of wait.
REQ-023 Simultaneous grant and accept on the same source SHALL free and reload the buffer in one edge without loss.
REQ-024 A transfer carrying label 0 SHALL be accepted, discarded (buffer stays empty) and SHALL set proto_err, which clears only on reset.
REQ-025 flush high at an edge SHALL empty every buffer, force BCEN to 0 for the following cycle, and preserve rr_ptr and bc_count.
REQ-026 bc_count SHALL increment on every edge registering BCEN=1 and saturate at 16'hFFFF.
REQ-027 BClabel and BCdata SHALL hold their previous values when BCEN is 0.

Reset
REQ-028 nRST low SHALL asynchronously clear all buffers, rr_ptr=0, BCEN=0, BClabel=0, BCdata=0, proto_err=0, bc_count=0.
REQ-029 src_ready SHALL read 0 while nRST is low and all-ones in the first cycle after release.
REQ-030 Reset asserted mid-operation SHALL drop pending results with no broadcast.

Structure
REQ-031 LABEL_W, DATA_W defaults and the label-0 "no producer" constant SHALL live in the shared head.v definitions used by the register file and reservation stations.
REQ-032 Round-robin grant SHALL be a sub-module rr_picker (request vector + pointer in, one-hot grant and valid out, combinational).
REQ-033 BCEN/BClabel/BCdata SHALL connect directly to the register file and reservation-station broadcast inputs without further logic.

Verification
REQ-034 Reset then src 2 sends label 5, data 32'h1234 -> BCEN=1, BClabel=5, BCdata=32'h1234 one edge later, bc_count=1.
REQ-035 All 4 sources valid at once (labels 1..4), rr_ptr=0 -> broadcasts in order 1,2,3,4 on consecutive cycles; src_ready low for the waiting sources.
REQ-036 Source 0 streams every cycle while source 1 is held full -> broadcasts alternate 0,1,0,1 (no starvation).
REQ-037 Source 3 sends label 0 -> no BCEN, proto_err=1 and remains 1 until nRST.
REQ-038 Three buffers full, flush pulsed -> BCEN=0 next cycle, no stale broadcasts afterwards, rr_ptr unchanged.
REQ-039 nRST asserted with two buffers full -> all outputs cleared immediately, no broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared common-data-bus definitions used by the register file, reservation stations
// and the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_SRC    = 4;
  localparam int unsigned CDB_DATA_W     = 32;
  localparam int unsigned CDB_LABEL_W    = 5;
  // A label of zero marks an operand with no outstanding producer.
  localparam int unsigned CDB_LABEL_NONE = 0;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or after the pointer wins.
module cdb_arbiter_rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid
);

  localparam logic [PTR_W:0] NumL = (PTR_W+1)'(N);

  always_comb begin
    logic [PTR_W:0] sum;
    logic [PTR_W:0] idx;
    o_grant = '0;
    o_valid = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned j = 0; j < N; j++) begin
      // Pointer and offset are both below N, so one conditional subtract wraps.
      sum = {1'b0, i_ptr} + j[PTR_W:0];
      idx = (sum >= NumL) ? sum - NumL : sum;
      if (!o_valid && i_req[idx[PTR_W-1:0]]) begin
        o_grant[idx[PTR_W-1:0]] = 1'b1;
        o_valid                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding buffer per source, round-robin broadcast of one
// result per cycle onto registered BCEN/BClabel/BCdata.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = CDB_NUM_SRC,
  parameter int unsigned DATA_W  = CDB_DATA_W,
  parameter int unsigned LABEL_W = CDB_LABEL_W
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*LABEL_W-1:0] src_label,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic                       proto_err,
  output logic [15:0]                bc_count
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]              r_full;
  logic [NUM_SRC-1:0][LABEL_W-1:0] r_label;
  logic [NUM_SRC-1:0][DATA_W-1:0]  r_data;
  logic [PTR_W-1:0]                r_ptr;
  logic                            r_bcen;
  logic [LABEL_W-1:0]              r_bclabel;
  logic [DATA_W-1:0]               r_bcdata;
  logic                            r_err;
  logic [15:0]                     r_cnt;

  logic [NUM_SRC-1:0] w_grant;
  logic               w_grant_valid;
  logic [NUM_SRC-1:0] w_accept;
  logic [NUM_SRC-1:0] w_label_ok;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [LABEL_W-1:0] w_sel_label;
  logic [DATA_W-1:0]  w_sel_data;

  cdb_arbiter_rr_picker #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_req   (r_full),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  // A granted buffer frees this edge, so it can take a new result at the same time.
  assign src_ready = (~r_full | w_grant) & {NUM_SRC{nRST & ~flush}};
  assign w_accept  = src_valid & src_ready;

  always_comb begin
    w_label_ok  = '0;
    w_ptr_next  = r_ptr;
    w_sel_label = '0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_label_ok[i] = src_label[i*LABEL_W +: LABEL_W] != LABEL_W'(CDB_LABEL_NONE);
      if (w_grant[i]) begin
        w_ptr_next  = (i == NUM_SRC - 1) ? '0 : PTR_W'(i + 1);
        w_sel_label = w_sel_label | r_label[i];
        w_sel_data  = w_sel_data | r_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_full    <= '0;
      r_label   <= '0;
      r_data    <= '0;
      r_ptr     <= '0;
      r_bcen    <= 1'b0;
      r_bclabel <= '0;
      r_bcdata  <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else if (flush) begin
      r_full <= '0;
      r_bcen <= 1'b0;
    end else begin
      r_bcen <= w_grant_valid;
      if (w_grant_valid) begin
        r_bclabel <= w_sel_label;
        r_bcdata  <= w_sel_data;
        r_ptr     <= w_ptr_next;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_accept[i]) begin
          // Label-0 transfers are taken off the source but never held.
          r_full[i]  <= w_label_ok[i];
          r_label[i] <= src_label[i*LABEL_W +: LABEL_W];
          r_data[i]  <= src_data[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      if ((w_accept & ~w_label_ok) != '0) r_err <= 1'b1;
    end
  end

  assign BCEN      = r_bcen;
  assign BClabel   = r_bclabel;
  assign BCdata    = r_bcdata;
  assign proto_err = r_err;
  assign bc_count  = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with 4 sources, 32-bit data and 5-bit labels.
module tb_cdb_arbiter;

  logic         clk;
  logic         nRST;
  logic         flush;
  logic [3:0]   src_valid;
  logic [19:0]  src_label;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         BCEN;
  logic [4:0]   BClabel;
  logic [31:0]  BCdata;
  logic         proto_err;
  logic [15:0]  bc_count;

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter #(
    .NUM_SRC (4),
    .DATA_W  (32),
    .LABEL_W (5)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .flush     (flush),
    .src_valid (src_valid),
    .src_label (src_label),
    .src_data  (src_data),
    .src_ready (src_ready),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .proto_err (proto_err),
    .bc_count  (bc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [4:0] l, input logic [31:0] d);
    src_valid[i]         = 1'b1;
    src_label[i*5 +: 5]  = l;
    src_data[i*32 +: 32] = d;
  endtask

  initial begin
    nRST      = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_label = '0;
    src_data  = '0;
    #1;
    check("rst_ready", src_ready, 0);
    check("rst_bcen", BCEN, 0);
    check("rst_label", BClabel, 0);
    check("rst_data", BCdata, 0);
    check("rst_err", proto_err, 0);
    check("rst_cnt", bc_count, 0);
    tick();
    nRST = 1'b1;
    #1;
    check("rel_ready", src_ready, 4'hF);

    // Single result from source 2
    drive(2, 5'd5, 32'h1234);
    tick();
    src_valid = '0;
    check("one_acc_bcen", BCEN, 0);
    check("one_acc_ready", src_ready, 4'hF);
    tick();
    check("one_bcen", BCEN, 1);
    check("one_label", BClabel, 5);
    check("one_data", BCdata, 32'h1234);
    check("one_cnt", bc_count, 1);
    tick();
    check("one_idle_bcen", BCEN, 0);
    check("one_hold_label", BClabel, 5);
    check("one_hold_data", BCdata, 32'h1234);

    // All four sources at once from rr_ptr=0
    #2 nRST = 1'b0;
    #1 nRST = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 5'(i + 1), 32'hA0 + 32'(i));
    tick();
    src_valid = '0;
    check("all_ready0", src_ready, 4'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("all_bcen", BCEN, 1);
      check("all_label", BClabel, 32'(k + 1));
      check("all_data", BCdata, 32'hA0 + 32'(k));
      if (k < 3) check("all_ready", src_ready, 32'((1 << (k + 2)) - 1));
    end
    tick();
    check("all_idle", BCEN, 0);
    check("all_cnt", bc_count, 4);

    // Source 0 streams while source 1 stays full
    drive(0, 5'd9, 32'h90);
    drive(1, 5'd10, 32'h100);
    tick();
    check("alt_load_bcen", BCEN, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("alt_bcen", BCEN, 1);
      check("alt_label", BClabel, (k % 2 == 0) ? 32'd9 : 32'd10);
    end
    src_valid = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("alt_drain", BClabel, (k == 0) ? 32'd9 : 32'd10);
    end
    tick();
    check("alt_idle", BCEN, 0);
    check("alt_cnt", bc_count, 10);

    // Label 0 from source 3
    drive(3, 5'd0, 32'hDEAD);
    tick();
    src_valid = '0;
    check("lz_bcen", BCEN, 0);
    check("lz_err", proto_err, 1);
    check("lz_ready", src_ready, 4'hF);
    tick();
    tick();
    check("lz_bcen2", BCEN, 0);
    check("lz_err_sticky", proto_err, 1);

    // Flush with three buffers full; rr_ptr is 2 here
    drive(0, 5'd11, 32'hB0);
    drive(1, 5'd12, 32'hB1);
    drive(2, 5'd13, 32'hB2);
    tick();
    src_valid = '0;
    flush     = 1'b1;
    #1;
    check("fl_ready", src_ready, 0);
    tick();
    flush = 1'b0;
    check("fl_bcen", BCEN, 0);
    check("fl_cnt", bc_count, 10);
    tick();
    check("fl_stale1", BCEN, 0);
    tick();
    check("fl_stale2", BCEN, 0);
    drive(0, 5'd14, 32'hC0);
    drive(3, 5'd15, 32'hC3);
    tick();
    src_valid = '0;
    tick();
    check("fl_ptr_first", BClabel, 15);
    tick();
    check("fl_ptr_second", BClabel, 14);
    check("fl_cnt2", bc_count, 12);

    // Reset with two buffers full
    drive(1, 5'd16, 32'h16);
    drive(2, 5'd17, 32'h17);
    tick();
    src_valid = '0;
    tick();
    check("mr_pre_label", BClabel, 16);
    #2 nRST = 1'b0;
    #1;
    check("mr_bcen", BCEN, 0);
    check("mr_label", BClabel, 0);
    check("mr_data", BCdata, 0);
    check("mr_err", proto_err, 0);
    check("mr_cnt", bc_count, 0);
    check("mr_ready", src_ready, 0);
    nRST = 1'b1;
    #1;
    check("mr_rel_ready", src_ready, 4'hF);
    tick();
    check("mr_post1", BCEN, 0);
    tick();
    check("mr_post2", BCEN, 0);
    check("mr_post_cnt", bc_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
